// File: rtl/alu_exec_ctrl_pkg.sv
// Shared types for the execute controller: ALU interface types, instruction
// field map, funct decode helper and FSM state encoding.
package alu_exec_ctrl_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLL = 3'd5,
      ALU_SRL = 3'd6,
      ALU_SRA = 3'd7
   } alu_opcode_t;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } alu_flags_t;

   typedef enum logic [3:0] {
      FN_ADD = 4'd0,
      FN_SUB = 4'd1,
      FN_AND = 4'd2,
      FN_OR  = 4'd3,
      FN_XOR = 4'd4,
      FN_SLL = 4'd5,
      FN_SRL = 4'd6,
      FN_SRA = 4'd7,
      FN_LDI = 4'd8
   } exec_funct_e;

   // imm for LDI is {rs2, imm_lo}: the two fields overlap in the encoding
   typedef struct packed {
      exec_funct_e funct;
      logic [1:0]  rd;
      logic [1:0]  rs1;
      logic [1:0]  rs2;
      logic [5:0]  imm_lo;
   } exec_instr_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } exec_state_e;

   localparam int EXEC_NREGS = 4;

   function automatic alu_opcode_t funct_to_alu_op(exec_funct_e f);
      alu_opcode_t op;
      case (f)
         FN_ADD:  op = ALU_ADD;
         FN_SUB:  op = ALU_SUB;
         FN_AND:  op = ALU_AND;
         FN_OR:   op = ALU_OR;
         FN_XOR:  op = ALU_XOR;
         FN_SLL:  op = ALU_SLL;
         FN_SRL:  op = ALU_SRL;
         FN_SRA:  op = ALU_SRA;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_exec_ctrl_regfile.sv
// 4-entry register file: two combinational operand reads, one debug read,
// one synchronous write port, asynchronously cleared.
module alu_regfile
   import alu_exec_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       rd_addr1,
   input  logic [1:0]       rd_addr2,
   input  logic [1:0]       dbg_addr,
   output logic [WIDTH-1:0] rd_data1,
   output logic [WIDTH-1:0] rd_data2,
   output logic [WIDTH-1:0] dbg_data,
   input  logic             wr_en,
   input  logic [1:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data
);

   logic [WIDTH-1:0] regs [EXEC_NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < EXEC_NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[wr_addr] <= wr_data;
      end
   end

   assign rd_data1 = regs[rd_addr1];
   assign rd_data2 = regs[rd_addr2];
   assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute controller: accepts instructions, drives an external
// combinational ALU, captures its output and writes back rf/result/flags.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | instr_ready=1; accept instruction, preload ALU operands
//   ST_EXEC | ALU inputs stable; capture alu_out/alu_flags at cycle end
//   ST_WB   | write back rf/result/flags (or flag illegal); done next cycle
module alu_exec_ctrl
   import alu_exec_ctrl_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr,
   output logic               instr_ready,
   output logic [WIDTH-1:0]   alu_in1,
   output logic [WIDTH-1:0]   alu_in2,
   output alu_opcode_t        alu_op,
   input  logic [WIDTH-1:0]   alu_out,
   input  alu_flags_t         alu_flags,
   output logic               done,
   output logic               illegal,
   output logic [WIDTH-1:0]   result,
   output alu_flags_t         flags_q,
   input  logic [1:0]         dbg_addr,
   output logic [WIDTH-1:0]   dbg_data
);

   exec_state_e      state, state_nx;
   exec_instr_t      in_w;
   logic [3:0]       in_fn;
   logic [3:0]       fn_q;
   logic [1:0]       rd_q;
   logic [7:0]       imm_q;
   logic [WIDTH-1:0] rd_data1, rd_data2;
   logic [WIDTH-1:0] out_q;
   alu_flags_t       flags_cap;
   logic             accept;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             q_is_alu, q_is_ldi, q_illegal;

   assign in_w  = instr;
   assign in_fn = in_w.funct;

   assign q_is_alu  = (fn_q[3] == 1'b0);
   assign q_is_ldi  = (fn_q == 4'd8);
   assign q_illegal = fn_q[3] && !q_is_ldi;

   alu_regfile #(.WIDTH(WIDTH)) u_rf (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr1 (in_w.rs1),
      .rd_addr2 (in_w.rs2),
      .dbg_addr (dbg_addr),
      .rd_data1 (rd_data1),
      .rd_data2 (rd_data2),
      .dbg_data (dbg_data),
      .wr_en    (wr_en),
      .wr_addr  (rd_q),
      .wr_data  (wr_data)
   );

   always_comb begin
      state_nx    = state;
      instr_ready = 1'b0;
      accept      = 1'b0;
      wr_en       = 1'b0;
      wr_data     = '0;
      case (state)
         ST_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               accept   = 1'b1;
               state_nx = in_fn[3] ? ST_WB : ST_EXEC;
            end
         end
         ST_EXEC: state_nx = ST_WB;
         ST_WB: begin
            state_nx = ST_IDLE;
            if (q_is_alu) begin
               wr_en   = 1'b1;
               wr_data = out_q;
            end else if (q_is_ldi) begin
               wr_en   = 1'b1;
               wr_data = WIDTH'(imm_q);
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Operands are registered at accept; nothing writes the rf between accept
   // and EXEC, so these equal rf[rs1]/rf[rs2] throughout EXEC and hold after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         fn_q      <= '0;
         rd_q      <= '0;
         imm_q     <= '0;
         alu_in1   <= '0;
         alu_in2   <= '0;
         alu_op    <= ALU_ADD;
         out_q     <= '0;
         flags_cap <= '0;
         result    <= '0;
         flags_q   <= '0;
         done      <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         state   <= state_nx;
         done    <= (state == ST_WB);
         illegal <= (state == ST_WB) && q_illegal;
         if (accept) begin
            fn_q  <= in_fn;
            rd_q  <= in_w.rd;
            imm_q <= {in_w.rs2, in_w.imm_lo};
            if (!in_fn[3]) begin
               alu_in1 <= rd_data1;
               alu_in2 <= rd_data2;
               alu_op  <= funct_to_alu_op(in_w.funct);
            end
         end
         if (state == ST_EXEC) begin
            out_q     <= alu_out;
            flags_cap <= alu_flags;
         end
         if (wr_en) begin
            result <= wr_data;
         end
         if ((state == ST_WB) && q_is_alu) begin
            flags_q <= flags_cap;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with an 8-bit reference ALU model wired
// to the controller's ALU ports.
module tb_alu_exec_ctrl;
   import alu_exec_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic [7:0]  alu_in1, alu_in2, alu_out;
   alu_opcode_t alu_op;
   alu_flags_t  alu_flags;
   logic        done, illegal;
   logic [7:0]  result;
   alu_flags_t  flags_q;
   logic [1:0]  dbg_addr;
   logic [7:0]  dbg_data;

   int checks   = 0;
   int failures = 0;

   always #10 clk = ~clk;

   alu_exec_ctrl #(.WIDTH(8), .INSTR_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_op      (alu_op),
      .alu_out     (alu_out),
      .alu_flags   (alu_flags),
      .done        (done),
      .illegal     (illegal),
      .result      (result),
      .flags_q     (flags_q),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   // reference ALU: c = carry (ADD) / borrow (SUB), v = signed overflow
   logic [8:0] wide;
   always_comb begin
      wide      = '0;
      alu_out   = '0;
      alu_flags = '0;
      case (alu_op)
         ALU_ADD: begin
            wide        = {1'b0, alu_in1} + {1'b0, alu_in2};
            alu_out     = wide[7:0];
            alu_flags.c = wide[8];
            alu_flags.v = (alu_in1[7] == alu_in2[7]) && (alu_out[7] != alu_in1[7]);
         end
         ALU_SUB: begin
            wide        = {1'b0, alu_in1} - {1'b0, alu_in2};
            alu_out     = wide[7:0];
            alu_flags.c = wide[8];
            alu_flags.v = (alu_in1[7] != alu_in2[7]) && (alu_out[7] != alu_in1[7]);
         end
         ALU_AND: alu_out = alu_in1 & alu_in2;
         ALU_OR:  alu_out = alu_in1 | alu_in2;
         ALU_XOR: alu_out = alu_in1 ^ alu_in2;
         ALU_SLL: alu_out = alu_in1 << alu_in2;
         ALU_SRL: alu_out = alu_in1 >> alu_in2;
         ALU_SRA: alu_out = 8'($signed(alu_in1) >>> alu_in2);
         default: alu_out = '0;
      endcase
      alu_flags.z = (alu_out == 8'h00);
      alu_flags.n = alu_out[7];
   end

   function automatic logic [15:0] op3(input logic [3:0] f, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2);
      return {f, rd, rs1, rs2, 6'b000000};
   endfunction

   function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
      return {4'h8, rd, 2'b00, imm};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
      dbg_addr = a;
      #1;
      check(tag, 32'(dbg_data), 32'(exp));
   endtask

   // Presents w at a negedge, accepts at the next posedge, then counts edges
   // until done is seen. Returns #1 after the done edge.
   task automatic issue(input string tag, input logic [15:0] w, input int exp_lat);
      int lat;
      lat = 0;
      @(negedge clk);
      check({tag, "_ready"}, 32'(instr_ready), 32'd1);
      instr_valid = 1'b1;
      instr       = w;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = k;
            break;
         end
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   logic [15:0] seq [3];
   int          acc_cyc [3];
   int          idx, dones, cyc;
   logic        rdy;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = '0;
      dbg_addr    = 2'd0;
      #45;
      check("rst_ready",   32'(instr_ready), 32'd1);
      check("rst_done",    32'(done),        32'd0);
      check("rst_illegal", 32'(illegal),     32'd0);
      check("rst_result",  32'(result),      32'd0);
      check("rst_flags",   32'(flags_q),     32'd0);
      check("rst_in1",     32'(alu_in1),     32'd0);
      check("rst_in2",     32'(alu_in2),     32'd0);
      check("rst_op",      32'(alu_op),      32'(ALU_ADD));
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) check_reg("rst_rf", 2'(i), 8'h00);

      // ADD r2 = r0 + r1
      issue("ldi_r0_01", ldi(2'd0, 8'h01), 1);
      check("ldi_r0_result", 32'(result), 32'h01);
      issue("ldi_r1_01", ldi(2'd1, 8'h01), 1);
      issue("add_r2", op3(4'h0, 2'd2, 2'd0, 2'd1), 2);
      check("add_result",  32'(result),  32'h02);
      check("add_illegal", 32'(illegal), 32'd0);
      check("add_flags",   32'(flags_q), 32'h0);
      check_reg("add_dbg_r2", 2'd2, 8'h02);
      @(posedge clk);
      #1;
      check("add_done_pulse", 32'(done), 32'd0);

      // SUB r3 = 0x00 - 0x01: z=0 n=1 c(borrow)=1 v=0
      issue("ldi_r0_00", ldi(2'd0, 8'h00), 1);
      issue("ldi_r1_01b", ldi(2'd1, 8'h01), 1);
      issue("sub_r3", op3(4'h1, 2'd3, 2'd0, 2'd1), 2);
      check("sub_result", 32'(result), 32'hFF);
      check("sub_flags",  32'(flags_q), 32'b0110);
      check_reg("sub_dbg_r3", 2'd3, 8'hFF);

      // shifts; LDI must leave flags alone
      issue("ldi_r0_80", ldi(2'd0, 8'h80), 1);
      check("ldi_keeps_flags", 32'(flags_q), 32'b0110);
      issue("ldi_r1_01c", ldi(2'd1, 8'h01), 1);
      issue("sll_r2", op3(4'h5, 2'd2, 2'd1, 2'd1), 2);
      check("sll_result", 32'(result), 32'h02);
      issue("sra_r0", op3(4'h7, 2'd0, 2'd0, 2'd1), 2);
      check("sra_result", 32'(result), 32'hC0);
      check("sra_flags",  32'(flags_q), 32'b0100);
      check_reg("sra_dbg_r0", 2'd0, 8'hC0);

      // illegal funct 0xF: rd=3 would be hit if it wrote
      issue("illegal", op3(4'hF, 2'd3, 2'd0, 2'd1), 1);
      check("illegal_pulse",  32'(illegal), 32'd1);
      check("illegal_result", 32'(result),  32'hC0);
      check("illegal_flags",  32'(flags_q), 32'b0100);
      check_reg("illegal_r0", 2'd0, 8'hC0);
      check_reg("illegal_r1", 2'd1, 8'h01);
      check_reg("illegal_r2", 2'd2, 8'h02);
      check_reg("illegal_r3", 2'd3, 8'hFF);

      // back-to-back with valid held high
      seq[0] = op3(4'h0, 2'd3, 2'd1, 2'd1);  // r3 = 1+1 = 02
      seq[1] = ldi(2'd0, 8'h55);
      seq[2] = op3(4'h4, 2'd1, 2'd0, 2'd3);  // r1 = 55^02 = 57
      idx   = 0;
      dones = 0;
      cyc   = 0;
      @(negedge clk);
      instr_valid = 1'b1;
      instr       = seq[0];
      while (dones < 3 && cyc < 30) begin
         rdy = instr_ready;
         @(posedge clk);
         #1;
         if (rdy && instr_valid) begin
            acc_cyc[idx] = cyc;
            idx++;
            if (idx == 3) instr_valid = 1'b0;
            else          instr = seq[idx];
         end
         if (done) dones++;
         cyc++;
         @(negedge clk);
      end
      instr_valid = 1'b0;
      check("b2b_accepts", 32'(idx),   32'd3);
      check("b2b_dones",   32'(dones), 32'd3);
      if (idx == 3) begin
         check("b2b_gap_alu", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
         check("b2b_gap_ldi", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
      end
      check_reg("b2b_r0", 2'd0, 8'h55);
      check_reg("b2b_r1", 2'd1, 8'h57);
      check_reg("b2b_r3", 2'd3, 8'h02);

      // reset during EXEC of ADD r2 = r0 + r1
      @(negedge clk);
      instr_valid = 1'b1;
      instr       = op3(4'h0, 2'd2, 2'd0, 2'd1);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      check("exec_in1",   32'(alu_in1),     32'h55);
      check("exec_in2",   32'(alu_in2),     32'h57);
      check("exec_op",    32'(alu_op),      32'(ALU_ADD));
      check("exec_ready", 32'(instr_ready), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_ready",  32'(instr_ready), 32'd1);
      check("abort_done",   32'(done),        32'd0);
      check("abort_result", 32'(result),      32'd0);
      check("abort_flags",  32'(flags_q),     32'd0);
      for (int i = 0; i < 4; i++) check_reg("abort_rf", 2'(i), 8'h00);
      dones = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      check("abort_no_done", 32'(dones), 32'd0);
      check_reg("abort_r2_late", 2'd2, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
